uart_tx_arbiter: RTL and testbench

- Shares the single fabric UART TX pin between two byte-stream requesters, e.g. the processor console and the debug/trace path.
- Contains an 8N1 serializer with an integer baud divider.
- Arbitrates by packet: a requester that starts a packet keeps the line until its last byte, so text lines never interleave.
- Sits between the soft-processor peripherals and the top-level TX output.

---
 rtl/uart_tx_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two byte-stream requesters share one 8N1 UART TX pin.
// Arbitration is per packet: a requester keeps the line from its first byte
// through the byte flagged last. With no lock, simultaneous requests are
// served round-robin. A lock whose owner goes quiet for LOCK_TIMEOUT cycles
// is dropped.
module uart_tx_arbiter #(
  parameter int BAUD_DIV     = 217,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [1:0] grant,
  output logic       busy,
  output logic       tx
);

  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  // The STOP state is one cycle shorter than a bit. The final stop-bit cycle
  // is the IDLE cycle, and the next byte can be accepted in that cycle. This
  // keeps back-to-back frames exactly 10*BAUD_DIV cycles apart.
  localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(BAUD_DIV - 2);

  localparam bit TIMEOUT_EN = (LOCK_TIMEOUT > 0);
  localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = TIMEOUT_EN ? CNT_W'(LOCK_TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t             state_reg, state_next;
  logic [BAUD_W-1:0]  baud_cnt_reg, baud_cnt_next;
  logic [2:0]         bit_idx_reg, bit_idx_next;
  logic [7:0]         shift_reg, shift_next;
  logic               tx_reg, tx_next;
  logic               stop_tail_reg;

  logic               lock_reg;
  logic               served_reg;   // index of the requester most recently accepted
  logic [CNT_W-1:0]   to_cnt_reg;

  logic [1:0]         valid_vec;
  logic [1:0]         elig_vec;
  logic [1:0]         ready_vec;
  logic [1:0]         accept_vec;
  logic               accept;
  logic               accept_idx;
  logic [7:0]         acc_data;
  logic               acc_last;
  logic               owner_valid;
  logic               timeout_hit;
  logic               grant_en;

  assign valid_vec   = {req1_valid, req0_valid};
  assign accept_vec  = ready_vec & valid_vec;
  assign accept      = |accept_vec;
  assign accept_idx  = accept_vec[1];
  assign acc_data    = accept_idx ? req1_data : req0_data;
  assign acc_last    = accept_idx ? req1_last : req0_last;
  assign owner_valid = valid_vec[served_reg];
  assign timeout_hit = TIMEOUT_EN && lock_reg && !owner_valid && (to_cnt_reg == TO_LAST);
  assign grant_en    = lock_reg || (state_reg != ST_IDLE);

  // Eligibility: the lock owner only; otherwise the sole requester, or on a
  // tie the one not served most recently.
  always_comb begin
    elig_vec = 2'b00;
    if (lock_reg) begin
      elig_vec[served_reg] = 1'b1;
    end else if (valid_vec == 2'b11) begin
      elig_vec[~served_reg] = 1'b1;
    end else begin
      elig_vec = valid_vec;
    end
  end

  // Per-requester ready and grant bits. grant[1] is req0 and grant[0] is req1.
  // Ready is held low while reset is asserted, so nothing is accepted then.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign ready_vec[gi] = !reset && (state_reg == ST_IDLE) && elig_vec[gi];
      assign grant[1-gi]   = grant_en && (served_reg == 1'(gi));
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  // busy also covers the final stop-bit cycle, which is spent in IDLE.
  assign busy = (state_reg != ST_IDLE) || stop_tail_reg;
  assign tx   = tx_reg;

  // Serializer next-state logic: bit timing, shifting, and the next pin level.
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          shift_next    = acc_data;
          baud_cnt_next = '0;
          state_next    = ST_START;
        end
      end
      ST_START: begin
        if (baud_cnt_reg == BAUD_LAST) begin
          baud_cnt_next = '0;
          bit_idx_next  = 3'd0;
          state_next    = ST_DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_cnt_reg == BAUD_LAST) begin
          baud_cnt_next = '0;
          shift_next    = {1'b0, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
            state_next = ST_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_cnt_reg == STOP_LAST) begin
          baud_cnt_next = '0;
          state_next    = ST_IDLE;
        end else begin
          baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    case (state_next)
      ST_START: tx_next = 1'b0;
      ST_DATA:  tx_next = shift_next[0];
      default:  tx_next = 1'b1;
    endcase
  end

  // Serializer registers. The pin is registered, so it is glitch-free, and reset forces it high at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      baud_cnt_reg  <= '0;
      bit_idx_reg   <= 3'd0;
      shift_reg     <= 8'h00;
      tx_reg        <= 1'b1;
      stop_tail_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      baud_cnt_reg  <= baud_cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      tx_reg        <= tx_next;
      stop_tail_reg <= (state_reg == ST_STOP) && (state_next == ST_IDLE);
    end
  end

  // Packet lock and round-robin history. Acceptance overrides a timeout in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_reg   <= 1'b0;
      served_reg <= 1'b1;
    end else if (accept) begin
      served_reg <= accept_idx;
      lock_reg   <= !acc_last;
    end else if (timeout_hit) begin
      lock_reg <= 1'b0;
    end
  end

  // Lock idle counter: it runs only while the lock is held and the owner is silent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_reg <= '0;
    end else if (accept || !lock_reg || owner_valid || timeout_hit) begin
      to_cnt_reg <= '0;
    end else if (TIMEOUT_EN) begin
      to_cnt_reg <= to_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter. Instance a uses
// BAUD_DIV=4 and LOCK_TIMEOUT=20. Instance b uses BAUD_DIV=2 and
// LOCK_TIMEOUT=30. The bench checks every cycle of each expected frame.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic reset;

  logic       a_req0_valid, a_req0_last, a_req0_ready;
  logic [7:0] a_req0_data;
  logic       a_req1_valid, a_req1_last, a_req1_ready;
  logic [7:0] a_req1_data;
  logic [1:0] a_grant;
  logic       a_busy, a_tx;

  logic       b_req0_valid, b_req0_last, b_req0_ready;
  logic [7:0] b_req0_data;
  logic       b_req1_valid, b_req1_last, b_req1_ready;
  logic [7:0] b_req1_data;
  logic [1:0] b_grant;
  logic       b_busy, b_tx;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(.BAUD_DIV(4), .LOCK_TIMEOUT(20)) dut_a (
    .clk(clk), .reset(reset),
    .req0_valid(a_req0_valid), .req0_data(a_req0_data), .req0_last(a_req0_last), .req0_ready(a_req0_ready),
    .req1_valid(a_req1_valid), .req1_data(a_req1_data), .req1_last(a_req1_last), .req1_ready(a_req1_ready),
    .grant(a_grant), .busy(a_busy), .tx(a_tx)
  );

  uart_tx_arbiter #(.BAUD_DIV(2), .LOCK_TIMEOUT(30)) dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_last(b_req0_last), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_last(b_req1_last), .req1_ready(b_req1_ready),
    .grant(b_grant), .busy(b_busy), .tx(b_tx)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic tx_of(input bit sel);
    return sel ? b_tx : a_tx;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? b_busy : a_busy;
  endfunction

  function automatic logic [1:0] grant_of(input bit sel);
    return sel ? b_grant : a_grant;
  endfunction

  function automatic logic [1:0] rdy_of(input bit sel);
    return sel ? {b_req0_ready, b_req1_ready} : {a_req0_ready, a_req1_ready};
  endfunction

  // The task is called just after the edge that starts a frame's start bit.
  // It checks each of the 10*div cycles and returns just after the edge that follows the frame.
  task automatic check_frame(input bit sel, input logic [7:0] b, input logic [1:0] exp_grant);
    int   div;
    logic exp_tx;
    string nm;
    div = sel ? 2 : 4;
    nm  = sel ? "b" : "a";
    $display("frame dut_%s byte=0x%02h grant=%b", nm, b, exp_grant);
    for (int bit_i = 0; bit_i < 10; bit_i++) begin
      if (bit_i == 0)      exp_tx = 1'b0;
      else if (bit_i == 9) exp_tx = 1'b1;
      else                 exp_tx = b[bit_i-1];
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        check_eq($sformatf("%s_tx_%02h_bit%0d_c%0d", nm, b, bit_i, c), 32'(tx_of(sel)), 32'(exp_tx));
        check_eq($sformatf("%s_busy_%02h_bit%0d_c%0d", nm, b, bit_i, c), 32'(busy_of(sel)), 32'd1);
        if (bit_i == 0 && c == 0)
          check_eq($sformatf("%s_grant_%02h", nm, b), 32'(grant_of(sel)), 32'(exp_grant));
        if (!(bit_i == 9 && c == div - 1))
          check_eq($sformatf("%s_rdy_mid_%02h_bit%0d", nm, b, bit_i), 32'(rdy_of(sel)), 32'd0);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_reset();
    a_req0_valid = 1'b0; a_req1_valid = 1'b0;
    b_req0_valid = 1'b0; b_req1_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    a_req0_valid = 1'b0; a_req0_data = 8'h00; a_req0_last = 1'b0;
    a_req1_valid = 1'b0; a_req1_data = 8'h00; a_req1_last = 1'b0;
    b_req0_valid = 1'b0; b_req0_data = 8'h00; b_req0_last = 1'b0;
    b_req1_valid = 1'b0; b_req1_data = 8'h00; b_req1_last = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state.
    @(negedge clk);
    check_eq("rst_tx_a", 32'(a_tx), 32'd1);
    check_eq("rst_busy_a", 32'(a_busy), 32'd0);
    check_eq("rst_grant_a", 32'(a_grant), 32'd0);
    check_eq("rst_rdy_a", 32'(rdy_of(0)), 32'd0);
    check_eq("rst_tx_b", 32'(b_tx), 32'd1);
    a_req0_valid = 1'b1;
    #1;
    check_eq("rst_rdy_gate", 32'(a_req0_ready), 32'd0);
    a_req0_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Single byte 0x55 from req0.
    $display("txn single req0 0x55");
    a_req0_valid = 1'b1; a_req0_data = 8'h55; a_req0_last = 1'b1;
    @(negedge clk);
    check_eq("t1_rdy", 32'(rdy_of(0)), 32'b10);
    check_eq("t1_busy_pre", 32'(a_busy), 32'd0);
    check_eq("t1_grant_pre", 32'(a_grant), 32'd0);
    @(posedge clk); #1;
    a_req0_valid = 1'b0;
    check_frame(0, 8'h55, 2'b10);
    @(negedge clk);
    check_eq("t1_busy_post", 32'(a_busy), 32'd0);
    check_eq("t1_grant_post", 32'(a_grant), 32'd0);
    check_eq("t1_tx_post", 32'(a_tx), 32'd1);
    @(posedge clk); #1;

    // Round-robin between single-byte requesters.
    $display("txn round robin");
    do_reset();
    a_req0_valid = 1'b1; a_req0_data = 8'hA0; a_req0_last = 1'b1;
    a_req1_valid = 1'b1; a_req1_data = 8'h5B; a_req1_last = 1'b1;
    @(negedge clk);
    check_eq("t2_rdy", 32'(rdy_of(0)), 32'b10);
    @(posedge clk); #1;
    check_frame(0, 8'hA0, 2'b10);
    check_frame(0, 8'h5B, 2'b01);
    check_frame(0, 8'hA0, 2'b10);

    // Packet lock: the three bytes from req0 hold off req1.
    $display("txn packet lock");
    do_reset();
    a_req0_valid = 1'b1; a_req0_data = 8'h41; a_req0_last = 1'b0;
    a_req1_valid = 1'b1; a_req1_data = 8'h77; a_req1_last = 1'b1;
    @(negedge clk);
    check_eq("t3_rdy", 32'(rdy_of(0)), 32'b10);
    @(posedge clk); #1;
    a_req0_data = 8'h42;
    check_frame(0, 8'h41, 2'b10);
    a_req0_data = 8'h43; a_req0_last = 1'b1;
    check_frame(0, 8'h42, 2'b10);
    a_req0_valid = 1'b0;
    check_frame(0, 8'h43, 2'b10);
    a_req1_valid = 1'b0;
    check_frame(0, 8'h77, 2'b01);

    // Lock timeout on instance a: req1 wins at the first idle cycle.
    $display("txn timeout a");
    do_reset();
    a_req0_valid = 1'b1; a_req0_data = 8'h31; a_req0_last = 1'b0;
    a_req1_valid = 1'b1; a_req1_data = 8'h62; a_req1_last = 1'b1;
    @(negedge clk);
    check_eq("t4_rdy", 32'(rdy_of(0)), 32'b10);
    @(posedge clk); #1;
    a_req0_valid = 1'b0;
    check_frame(0, 8'h31, 2'b10);
    a_req1_valid = 1'b0;
    check_frame(0, 8'h62, 2'b01);

    // Exact timeout cycle on instance b. The frame ends before the lock is released.
    $display("txn timeout b");
    do_reset();
    b_req0_valid = 1'b1; b_req0_data = 8'h10; b_req0_last = 1'b0;
    b_req1_valid = 1'b1; b_req1_data = 8'h20; b_req1_last = 1'b1;
    @(negedge clk);
    check_eq("t5_rdy", 32'(rdy_of(1)), 32'b10);
    @(posedge clk); #1;
    b_req0_valid = 1'b0;
    check_frame(1, 8'h10, 2'b10);
    for (int k = 21; k <= 30; k++) begin
      @(negedge clk);
      check_eq($sformatf("t5_locked_rdy_c%0d", k), 32'(rdy_of(1)), 32'b10);
      check_eq($sformatf("t5_locked_grant_c%0d", k), 32'(b_grant), 32'b10);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_eq("t5_release_rdy", 32'(rdy_of(1)), 32'b01);
    check_eq("t5_release_grant", 32'(b_grant), 32'd0);
    @(posedge clk); #1;
    b_req1_valid = 1'b0;
    check_frame(1, 8'h20, 2'b01);

    // Back-to-back 0xFF then 0x00 with BAUD_DIV=2.
    $display("txn ff then 00 b");
    b_req1_valid = 1'b1; b_req1_data = 8'hFF; b_req1_last = 1'b1;
    @(negedge clk);
    check_eq("t6_rdy", 32'(rdy_of(1)), 32'b01);
    @(posedge clk); #1;
    b_req1_data = 8'h00;
    check_frame(1, 8'hFF, 2'b01);
    b_req1_valid = 1'b0;
    check_frame(1, 8'h00, 2'b01);
    @(negedge clk);
    check_eq("t6_busy_post", 32'(b_busy), 32'd0);
    @(posedge clk); #1;

    // Reset asserted during data bit 3.
    $display("txn reset mid frame");
    a_req1_valid = 1'b1; a_req1_data = 8'h35; a_req1_last = 1'b1;
    @(negedge clk);
    check_eq("t7_rdy", 32'(rdy_of(0)), 32'b01);
    @(posedge clk); #1;
    repeat (17) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("t7_tx_bit3", 32'(a_tx), 32'd0);
    check_eq("t7_busy_pre", 32'(a_busy), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("t7_tx_async", 32'(a_tx), 32'd1);
    check_eq("t7_busy_async", 32'(a_busy), 32'd0);
    check_eq("t7_grant_async", 32'(a_grant), 32'd0);
    check_eq("t7_rdy_in_reset", 32'(rdy_of(0)), 32'd0);
    a_req1_data = 8'hC5;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("t7_rdy_after", 32'(rdy_of(0)), 32'b01);
    check_eq("t7_tx_after", 32'(a_tx), 32'd1);
    @(posedge clk); #1;
    a_req1_valid = 1'b0;
    check_frame(0, 8'hC5, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
